flag_cond_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Holds the architectural Z/N/V flag register, written from the saturating adder's zr/neg/ov outputs under per-flag write enables.
- Tracks in-flight flag-setting instructions and resolves 3-bit branch conditions against the committed flags.
- Stalls a branch until every older flag writer has retired.
- Sits between the EX/WB flag path and the fetch redirect logic.

---
 rtl/flag_cond_unit_pkg.sv | 26 ++
 rtl/flag_cond_unit_cond_eval.sv | 32 +++
 rtl/flag_cond_unit.sv | 122 ++++++++++++
 tb/tb_flag_cond_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flag_cond_unit_pkg.sv
// Shared types for the flag/condition unit: condition codes, flag bit
// positions and the branch-resolution FSM encoding.
package flag_cond_unit_pkg;

  typedef enum logic [2:0] {
    COND_NE = 3'd0,
    COND_EQ = 3'd1,
    COND_GT = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_LE = 3'd5,
    COND_OV = 3'd6,
    COND_UN = 3'd7
  } cond_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } fsm_t;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational condition evaluator: {Z,N,V} flags + condition code -> taken.
// Also reused by the ALU-side compare logic.
module cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic z, n, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~z & ~n;
      COND_LT: taken = n;
      COND_GE: taken = z | (~z & ~n);
      COND_LE: taken = n | z;
      COND_OV: taken = v;
      COND_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural Z/N/V flag register, outstanding flag-writer tracking and
// branch condition resolution. Define FLAG_FWD_EN to let a branch resolve
// directly against the last writer's flags in the cycle that writer retires.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fw_issue,
  output logic       issue_ready,
  input  logic       alu_valid,
  input  logic       alu_zr,
  input  logic       alu_neg,
  input  logic       alu_ov,
  input  logic [2:0] flag_we,
  input  logic       br_valid,
  input  logic [2:0] br_cond,
  output logic       br_ready,
  output logic       br_done,
  output logic       br_taken,
  output logic [2:0] flags
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [2:0]        flags_q, flags_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  fsm_t              state_q;
  logic [2:0]        cond_q;
  logic              done_q, taken_q;
  logic              iss_acc, retire, fwd_hit, taken_d;
  logic [2:0]        cond_sel;

  always_comb begin
    flags_d = flags_q;
    if (alu_valid) begin
      if (flag_we[FLAG_Z]) flags_d[FLAG_Z] = alu_zr;
      if (flag_we[FLAG_N]) flags_d[FLAG_N] = alu_neg;
      if (flag_we[FLAG_V]) flags_d[FLAG_V] = alu_ov;
    end
  end

  assign issue_ready = (pend_q != PEND_MAX);
  assign iss_acc     = fw_issue & issue_ready;
  // A writeback with nothing outstanding still updates flags but never underflows.
  assign retire      = alu_valid & (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (iss_acc & ~retire)      pend_d = pend_q + PEND_ONE;
    else if (retire & ~iss_acc) pend_d = pend_q - PEND_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
      pend_q  <= '0;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
    end
  end

  // Evaluate against next-cycle flags so br_taken matches the flags visible during RESOLVE.
  assign cond_sel = (state_q == ST_IDLE) ? br_cond : cond_q;

  cond_eval u_cond_eval (
    .flags (flags_d),
    .cond  (cond_sel),
    .taken (taken_d)
  );

`ifdef FLAG_FWD_EN
  assign fwd_hit = alu_valid & (pend_q == PEND_ONE);
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cond_q  <= 3'b000;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            cond_q <= br_cond;
            // Pending count before this cycle's issue: a same-cycle issue is younger.
            if ((pend_q == '0) || fwd_hit) begin
              state_q <= ST_RESOLVE;
              done_q  <= 1'b1;
              taken_q <= taken_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (pend_d == '0) begin
            state_q <= ST_RESOLVE;
            done_q  <= 1'b1;
            taken_q <= taken_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign br_ready = (state_q == ST_IDLE);
  assign br_done  = done_q;
  assign br_taken = taken_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_flag_cond_unit;

  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fw_issue, alu_valid, alu_zr, alu_neg, alu_ov, br_valid;
  logic [2:0] flag_we, br_cond;
  logic       issue_ready, br_ready, br_done, br_taken;
  logic [2:0] flags;

  int n_cmp = 0;
  int n_err = 0;

  flag_cond_unit #(.PEND_W(PEND_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .fw_issue    (fw_issue),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_zr      (alu_zr),
    .alu_neg     (alu_neg),
    .alu_ov      (alu_ov),
    .flag_we     (flag_we),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_ready    (br_ready),
    .br_done     (br_done),
    .br_taken    (br_taken),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Condition table written straight from the code definitions.
  function automatic logic ev(input logic [2:0] c, input logic [2:0] f);
    logic z, n, v;
    z = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: integer writer count, a branch "outstanding" bit and a done pulse.
  logic [2:0] m_flags, m_nf, m_cond;
  int         m_pend, m_old;
  bit         m_busy, m_done, m_taken, m_go;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flags = 3'b000; m_pend = 0; m_busy = 0; m_done = 0; m_taken = 0; m_cond = 3'b000;
    end else begin
      m_old = m_pend;
      m_nf  = m_flags;
      if (alu_valid) begin
        if (flag_we[2]) m_nf[2] = alu_zr;
        if (flag_we[1]) m_nf[1] = alu_neg;
        if (flag_we[0]) m_nf[0] = alu_ov;
      end
      m_pend = m_old + ((fw_issue && m_old < PMAX) ? 1 : 0) - ((alu_valid && m_old > 0) ? 1 : 0);
      m_go = 0;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy && br_valid) begin
        m_busy = 1; m_cond = br_cond;
        m_go = (m_old == 0) || (FWD && m_old == 1 && alu_valid);
      end else if (m_busy) begin
        m_go = (m_pend == 0);
      end
      m_taken = 0;
      if (m_go) begin
        m_done = 1;
        m_taken = ev(m_cond, m_nf);
      end
      m_flags = m_nf;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("flags", flags, m_flags);
      chk("issue_ready", issue_ready, (m_pend != PMAX));
      chk("br_ready", br_ready, !m_busy);
      chk("br_done", br_done, m_done);
      if (m_done) chk("br_taken", br_taken, m_taken);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    fw_issue = 0; alu_valid = 0; alu_zr = 0; alu_neg = 0; alu_ov = 0;
    flag_we = 3'b000; br_valid = 0; br_cond = 3'b000;
  endtask

  task automatic alu(input logic [2:0] we, input logic z, input logic n, input logic v);
    alu_valid = 1; flag_we = we; alu_zr = z; alu_neg = n; alu_ov = v;
    step();
    alu_valid = 0; flag_we = 3'b000;
  endtask

  task automatic do_branch(input string nm, input logic [2:0] c, input logic exp_t, input int exp_lat);
    int w, lat;
    w = 0;
    while (!br_ready && w < 50) begin step(); w++; end
    chk({nm, "_rdy"}, br_ready, 1'b1);
    br_valid = 1; br_cond = c; lat = 0;
    do begin
      step(); br_valid = 0; lat++;
    end while (!br_done && lat < 50);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_taken"}, br_taken, exp_t);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    #1 rst = 1;
    step(); step();
    chk("rst_flags", flags, 3'b000);
    chk("rst_br_ready", br_ready, 1'b1);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_br_done", br_done, 1'b0);
    rst = 0;
    step();

    // 1: unconditional branch, nothing pending
    do_branch("t1", 3'b111, 1'b1, 1);
    chk("t1_flags", flags, 3'b000);

    // 2: Z set, EQ taken / NE not taken
    alu(3'b111, 1, 0, 0);
    do_branch("t2_eq", 3'b001, 1'b1, 1);
    do_branch("t2_ne", 3'b000, 1'b0, 1);

    // 3: two writers in flight stall an LT branch
    fw_issue = 1; step(); step(); fw_issue = 0;
    br_valid = 1; br_cond = 3'b011; step(); br_valid = 0;
    chk("t3_wait_rdy", br_ready, 1'b0);
    chk("t3_wait_done", br_done, 1'b0);
    alu(3'b010, 0, 1, 0);
    chk("t3_still_wait", br_done, 1'b0);
    alu(3'b010, 0, 1, 0);
    chk("t3_done", br_done, 1'b1);
    chk("t3_taken", br_taken, 1'b1);
    step();

    // 4: partial flag write
    alu(3'b111, 1, 0, 0);
    chk("t4_flags100", flags, 3'b100);
    alu(3'b001, 0, 0, 1);
    chk("t4_flags101", flags, 3'b101);
    do_branch("t4_ov", 3'b110, 1'b1, 1);
    do_branch("t4_gt", 3'b010, 1'b0, 1);

    // 5: counter saturation
    fw_issue = 1;
    step(); chk("t5_ir1", issue_ready, 1'b1);
    step(); chk("t5_ir2", issue_ready, 1'b1);
    step(); chk("t5_ir3", issue_ready, 1'b0);
    step(); chk("t5_ir4", issue_ready, 1'b0);
    fw_issue = 0;
    alu(3'b000, 0, 0, 0);
    chk("t5_after_ret", issue_ready, 1'b1);
    alu(3'b000, 0, 0, 0);
    alu(3'b000, 0, 0, 0);
    do_branch("t5_drained", 3'b111, 1'b1, 1);

    // 6: reset during WAIT
    fw_issue = 1; step(); fw_issue = 0;
    br_valid = 1; br_cond = 3'b111; step(); br_valid = 0;
    chk("t6_wait", br_ready, 1'b0);
    rst = 1; step();
    chk("t6_rst_rdy", br_ready, 1'b1);
    chk("t6_rst_done", br_done, 1'b0);
    chk("t6_rst_flags", flags, 3'b000);
    chk("t6_rst_ir", issue_ready, 1'b1);
    rst = 0; step();
    chk("t6_no_done", br_done, 1'b0);
    do_branch("t6_after", 3'b111, 1'b1, 1);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        idle_in(); rst = 1; step(); rst = 0;
      end else begin
        fw_issue  = ($urandom_range(2) == 0);
        alu_valid = ($urandom_range(2) == 0);
        alu_zr    = 1'($urandom);
        alu_neg   = 1'($urandom);
        alu_ov    = 1'($urandom);
        flag_we   = 3'($urandom);
        br_valid  = ($urandom_range(2) == 0);
        br_cond   = 3'($urandom);
        step();
      end
    end
    idle_in();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
